axi_lite_regfile_slave: RTL

Synthesizable AXI4-Lite responder that terminates the bridge's target-side AXI4-Lite master port (tgt_m_*).
- Replaces the behavioural memory model when PCI target accesses (BAR0/BAR1/IO) must land in real registers.
- Holds NUM_WORDS 32-bit registers with byte-strobed writes and byte-enable-masked reads, carried on aruser.
- Decodes a window at BASE_ADDR; any access outside the window returns DECERR.

---
 rtl/axi_lite_regfile_slave_pkg.sv | 22 ++
 rtl/axi_lite_regfile_slave_if.sv | 52 +++++
 rtl/axi_lite_regfile_mem.sv | 39 +++
 rtl/axi_lite_regfile_slave.sv | 140 ++++++++++++++
 4 files changed

// File: rtl/axi_lite_regfile_slave_pkg.sv
// axi_lite_pkg: shared AXI4-Lite definitions for the register-file responder.
//   - resp_t and the RESP_* response codes carried on bresp/rresp
//   - lane_mask(): expands a 4-bit byte strobe / byte enable into a 32-bit mask
package axi_lite_pkg;

  typedef logic [1:0] resp_t;

  localparam resp_t RESP_OKAY   = 2'b00;
  localparam resp_t RESP_SLVERR = 2'b10;
  localparam resp_t RESP_DECERR = 2'b11;

  // Each enable bit i covers byte lane [8*i+7:8*i].
  function automatic logic [31:0] lane_mask(input logic [3:0] en);
    logic [31:0] m;
    m = '0;
    for (int i = 0; i < 4; i++) begin
      m[8*i +: 8] = {8{en[i]}};
    end
    return m;
  endfunction

endpackage

// File: rtl/axi_lite_regfile_slave_if.sv
// axi_lite_regfile_slave_if: AXI4-Lite bus bundle (AW, W, B, AR, R channels).
//   The AR channel carries a 4-bit aruser holding per-lane read byte enables.
//   modport slave  : the register-file responder side
//   modport master : the requester side (bridge target port or a testbench)
interface axi_lite_regfile_slave_if #(
  parameter int ADDR_WIDTH = 32
);
  logic                  s_axi_awvalid;
  logic                  s_axi_awready;
  logic [ADDR_WIDTH-1:0] s_axi_awaddr;
  logic                  s_axi_wvalid;
  logic                  s_axi_wready;
  logic [31:0]           s_axi_wdata;
  logic [3:0]            s_axi_wstrb;
  logic                  s_axi_bvalid;
  logic                  s_axi_bready;
  logic [1:0]            s_axi_bresp;
  logic                  s_axi_arvalid;
  logic                  s_axi_arready;
  logic [ADDR_WIDTH-1:0] s_axi_araddr;
  logic [3:0]            s_axi_aruser;
  logic                  s_axi_rvalid;
  logic                  s_axi_rready;
  logic [31:0]           s_axi_rdata;
  logic [1:0]            s_axi_rresp;

  modport slave (
    input  s_axi_awvalid, s_axi_awaddr,
    output s_axi_awready,
    input  s_axi_wvalid, s_axi_wdata, s_axi_wstrb,
    output s_axi_wready,
    output s_axi_bvalid, s_axi_bresp,
    input  s_axi_bready,
    input  s_axi_arvalid, s_axi_araddr, s_axi_aruser,
    output s_axi_arready,
    output s_axi_rvalid, s_axi_rdata, s_axi_rresp,
    input  s_axi_rready
  );

  modport master (
    output s_axi_awvalid, s_axi_awaddr,
    input  s_axi_awready,
    output s_axi_wvalid, s_axi_wdata, s_axi_wstrb,
    input  s_axi_wready,
    input  s_axi_bvalid, s_axi_bresp,
    output s_axi_bready,
    output s_axi_arvalid, s_axi_araddr, s_axi_aruser,
    input  s_axi_arready,
    input  s_axi_rvalid, s_axi_rdata, s_axi_rresp,
    output s_axi_rready
  );
endinterface

// File: rtl/axi_lite_regfile_mem.sv
// axi_lite_regfile_mem: NUM_WORDS x 32-bit register array.
//   clk, rst      : clock, asynchronous active-high reset (clears every word)
//   we/waddr      : write enable and word index
//   wstrb/wdata   : per-byte write strobes and write data
//   raddr/rdata   : combinational read port (returns the pre-write value on
//                   the edge a write to the same word lands)
module axi_lite_regfile_mem #(
  parameter int NUM_WORDS = 64,
  parameter int IDX_W     = $clog2(NUM_WORDS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             we,
  input  logic [IDX_W-1:0] waddr,
  input  logic [3:0]       wstrb,
  input  logic [31:0]      wdata,
  input  logic [IDX_W-1:0] raddr,
  output logic [31:0]      rdata
);

  logic [31:0] mem [NUM_WORDS];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_WORDS; i++) begin
        mem[i] <= '0;
      end
    end else if (we) begin
      for (int b = 0; b < 4; b++) begin
        if (wstrb[b]) begin
          mem[waddr][8*b +: 8] <= wdata[8*b +: 8];
        end
      end
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/axi_lite_regfile_slave.sv
// axi_lite_regfile_slave: AXI4-Lite responder backed by NUM_WORDS 32-bit
// registers, decoded in a window starting at BASE_ADDR. Accesses outside the
// window answer DECERR and leave the registers untouched.
//   s_axi_aclk : clock
//   rst        : asynchronous active-high reset
//   bus        : axi_lite_regfile_slave_if.slave (AW/W/B/AR/R, aruser = read
//                byte enables, disabled lanes read as 8'h00)
// Build option: define AXIL_REGFILE_ID_EN to make word 0 a read-only ID
// register returning ID_VALUE; writes to it are dropped but answer OKAY.
module axi_lite_regfile_slave
  import axi_lite_pkg::*;
#(
  parameter int                    ADDR_WIDTH = 32,
  parameter int                    NUM_WORDS  = 64,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = 32'h8002_0000,
  parameter logic [31:0]           ID_VALUE   = 32'h6120_0001
) (
  input logic                     s_axi_aclk,
  input logic                     rst,
  axi_lite_regfile_slave_if.slave bus
);

  localparam int IDX_W = $clog2(NUM_WORDS);
  localparam logic [ADDR_WIDTH-3:0] WORDS_LIM = (ADDR_WIDTH-2)'(NUM_WORDS);

`ifdef AXIL_REGFILE_ID_EN
  localparam bit ID_EN = 1'b1;
`else
  localparam bit ID_EN = 1'b0;
`endif

  typedef struct packed {
    logic             hit;
    logic [IDX_W-1:0] idx;
  } dec_t;

  // Word offset from the window base; the full-width compare rejects
  // addresses below BASE_ADDR, whose subtraction would otherwise wrap.
  function automatic dec_t decode(input logic [ADDR_WIDTH-1:0] a);
    dec_t                  d;
    logic [ADDR_WIDTH-3:0] woff;
    woff  = a[ADDR_WIDTH-1:2] - BASE_ADDR[ADDR_WIDTH-1:2];
    d.hit = (a >= BASE_ADDR) && (woff < WORDS_LIM);
    d.idx = woff[IDX_W-1:0];
    return d;
  endfunction

  logic                  aw_held, w_held;
  logic [ADDR_WIDTH-1:0] aw_addr_q;
  logic [31:0]           w_data_q;
  logic [3:0]            w_strb_q;
  logic                  bvalid_q;
  resp_t                 bresp_q;
  logic                  rvalid_q;
  resp_t                 rresp_q;
  logic [31:0]           rdata_q;

  logic        aw_fire, w_fire, ar_fire, arready;
  logic        wr_commit, wr_ro, mem_we;
  dec_t        wr_dec, rd_dec;
  logic [31:0] mem_rdata, rd_word;

  assign arready   = !rvalid_q || bus.s_axi_rready;
  assign aw_fire   = bus.s_axi_awvalid && !aw_held;
  assign w_fire    = bus.s_axi_wvalid && !w_held;
  assign ar_fire   = bus.s_axi_arvalid && arready;

  // A write retires once both halves are held and the B slot is free.
  assign wr_commit = aw_held && w_held && (!bvalid_q || bus.s_axi_bready);
  assign wr_dec    = decode(aw_addr_q);
  assign rd_dec    = decode(bus.s_axi_araddr);
  assign wr_ro     = ID_EN && (wr_dec.idx == '0);
  assign mem_we    = wr_commit && wr_dec.hit && !wr_ro;
  assign rd_word   = (ID_EN && (rd_dec.idx == '0)) ? ID_VALUE : mem_rdata;

  axi_lite_regfile_mem #(
    .NUM_WORDS (NUM_WORDS),
    .IDX_W     (IDX_W)
  ) u_mem (
    .clk   (s_axi_aclk),
    .rst   (rst),
    .we    (mem_we),
    .waddr (wr_dec.idx),
    .wstrb (w_strb_q),
    .wdata (w_data_q),
    .raddr (rd_dec.idx),
    .rdata (mem_rdata)
  );

  // Handshake control and response registers
  always_ff @(posedge s_axi_aclk or posedge rst) begin
    if (rst) begin
      aw_held  <= 1'b0;
      w_held   <= 1'b0;
      bvalid_q <= 1'b0;
      bresp_q  <= RESP_OKAY;
      rvalid_q <= 1'b0;
      rresp_q  <= RESP_OKAY;
      rdata_q  <= '0;
    end else begin
      if (wr_commit) begin
        aw_held  <= 1'b0;
        w_held   <= 1'b0;
        bvalid_q <= 1'b1;
        bresp_q  <= wr_dec.hit ? RESP_OKAY : RESP_DECERR;
      end else begin
        if (aw_fire) aw_held <= 1'b1;
        if (w_fire)  w_held  <= 1'b1;
        if (bvalid_q && bus.s_axi_bready) bvalid_q <= 1'b0;
      end

      if (ar_fire) begin
        rvalid_q <= 1'b1;
        rresp_q  <= rd_dec.hit ? RESP_OKAY : RESP_DECERR;
        rdata_q  <= rd_dec.hit ? (rd_word & lane_mask(bus.s_axi_aruser)) : '0;
      end else if (bus.s_axi_rready) begin
        rvalid_q <= 1'b0;
      end
    end
  end

  // Captured AW/W payload; only meaningful while the matching held flag is set
  always_ff @(posedge s_axi_aclk) begin
    if (aw_fire) aw_addr_q <= bus.s_axi_awaddr;
    if (w_fire) begin
      w_data_q <= bus.s_axi_wdata;
      w_strb_q <= bus.s_axi_wstrb;
    end
  end

  assign bus.s_axi_awready = !aw_held;
  assign bus.s_axi_wready  = !w_held;
  assign bus.s_axi_bvalid  = bvalid_q;
  assign bus.s_axi_bresp   = bresp_q;
  assign bus.s_axi_arready = arready;
  assign bus.s_axi_rvalid  = rvalid_q;
  assign bus.s_axi_rresp   = rresp_q;
  assign bus.s_axi_rdata   = rdata_q;

endmodule
